al_const_capture: RTL and testbench
===================================

Name: al_const_capture

Overview:
- Downstream consumer of the flash auto-load sequencer and the BPI interface FSM.
- Captures each 16-bit word read from the last parameter block (CAP strobe plus word index) into a staging bank.
- Checks header magic, word order and checksum.
- On success, atomically swaps the staging bank into the active bank that the rest of the DCFEB reads constants from.
- Returns AL_DONE to the sequencer.

Parameters:
- NWORDS, 34: words per auto-load image. Word 0 is the magic, words 1..NWORDS-2 are constants, word NWORDS-1 is the checksum.
- MAGIC, 16'hDCFB: required value of word 0.
- AW, 6: index/address width; NWORDS must be ≤ 2^AW.
- TIMEOUT_CYC, 1024: inter-word watchdog limit. Used only with AL_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; arms capture of a new image (same pulse as AL_START to the sequencer)
- CLR_AL_DONE  in  1  one-cycle pulse from the sequencer; clears AL_DONE
- CAPTURE  in  1  one-cycle strobe from the BPI interface FSM CAP output; DATA_IN is valid
- CNT  in  AW  word index of the current capture (sequencer AL_CNT)
- DATA_IN  in  16  flash read data
- RD_ADDR  in  AW  constant read address into the active bank
- RD_DATA  out  16  active-bank word, registered, 1-cycle latency
- AL_DONE  out  1  sticky; image finished, pass or fail
- CONST_VALID  out  1  active bank holds a verified image
- MAGIC_ERR  out  1  sticky error flag
- SEQ_ERR  out  1  sticky error flag
- CSUM_ERR  out  1  sticky error flag
- TMO_ERR  out  1  sticky error flag
- WORD_CNT  out  AW  number of words accepted in the current image

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, active bank = 0, running sum 0. Reset mid-image abandons the image. Bank contents are not cleared, but CONST_VALID=0.
- States:
  - IDLE: CAPTURE ignored. START → COLLECT; clears WORD_CNT, sum, all four error flags and AL_DONE.
  - COLLECT: on CAPTURE with CNT==WORD_CNT and CNT<NWORDS:
    - write DATA_IN to the staging bank at CNT (next edge);
    - WORD_CNT+1;
    - for CNT<NWORDS-1: sum ← (sum+DATA_IN) mod 2^16;
    - CNT==0 and DATA_IN≠MAGIC → MAGIC_ERR=1, go to ERROR;
    - CNT==NWORDS-1: latch DATA_IN as the expected checksum, go to CHECK.
  - COLLECT, mismatched capture: CAPTURE with CNT≠WORD_CNT or CNT≥NWORDS → SEQ_ERR=1, go to ERROR. No write.
  - CHECK (1 cycle): compare sum with the latched checksum.
    - Equal → DONE.
    - Not equal → CSUM_ERR=1, go to ERROR.
  - DONE: on entry, active bank toggles (staging becomes active), CONST_VALID=1, AL_DONE=1.
  - ERROR: on entry, AL_DONE=1. Active bank and CONST_VALID are unchanged, so a previous good image stays in use.
  - DONE/ERROR: return to IDLE on the cycle after entry.
- Latency: last-word CAPTURE sampled at edge k; AL_DONE, CONST_VALID and the bank swap are visible after edge k+2.
- AL_DONE: stays 1 until CLR_AL_DONE or START. CLR_AL_DONE while AL_DONE=0 has no effect.
- Simultaneous events:
  - START with CAPTURE in any state: START wins, capture dropped.
  - START in COLLECT or CHECK: restarts the image; staging bank is overwritten; no swap.
  - CLR_AL_DONE in the same cycle as the AL_DONE set: set wins.
- Read port:
  - RD_DATA = active_bank[RD_ADDR], registered.
  - RD_ADDR≥NWORDS → RD_DATA=0.
  - A bank swap is seen by the read issued on the cycle after the swap edge.
- Widths: sum wraps mod 2^16. WORD_CNT saturates at NWORDS.

Optional Feature:
- Macro: AL_TIMEOUT_EN.
- Defined:
  - a counter runs in COLLECT and resets on each accepted CAPTURE and on START;
  - reaching TIMEOUT_CYC-1 → TMO_ERR=1, go to ERROR (AL_DONE=1).
- Undefined: no counter; TMO_ERR is tied to 0; COLLECT waits indefinitely.

Decomposition:
- Package al_const_pkg holds:
  - state enum {IDLE, COLLECT, CHECK, DONE, ERROR};
  - default MAGIC, NWORDS, AW;
  - word-role index constants (HDR_IDX=0, CSUM_IDX=NWORDS-1).
- Sub-module al_const_bank: two NWORDS×16 register banks, each with a write port selected by ~active. It contains:
  - a registered read port on the active bank;
  - the toggle-on-commit select flop.

Test Plan:
- Good image: START; 34 in-order captures; word0=16'hDCFB, words 1..32 = index value i, word33 = 16'h(DCFB+0210) mod 2^16 = 16'hDF0B. → AL_DONE=1 two cycles after the last capture, CONST_VALID=1, RD_ADDR=5 → RD_DATA=16'h0005 one cycle later, all error flags 0.
- Bad magic: word0=16'h1234. → MAGIC_ERR=1, AL_DONE=1 next cycle, CONST_VALID unchanged. The prior image is still readable.
- Checksum fail: the good image with word33=16'hDF0C. → CSUM_ERR=1, AL_DONE=1, no bank swap (RD_ADDR=5 still returns the old value).
- Order fault: capture CNT=0,1,3. → SEQ_ERR=1 at the third capture; WORD_CNT=2; the third word is not written.
- Handshake and restart:
  - START at word 10 → WORD_CNT=0, flags clear, and a subsequent good image passes.
  - CLR_AL_DONE after DONE → AL_DONE=0 next cycle.
  - RST mid-image → all outputs 0.
- Watchdog (AL_TIMEOUT_EN, TIMEOUT_CYC=16): stop captures after word 3. → TMO_ERR=1 and AL_DONE=1 16 cycles after the last accepted capture. Without the macro, TMO_ERR stays 0 and the state remains COLLECT.

Source files
------------

// File: rtl/al_const_capture_pkg.sv
// al_const_pkg: shared states, image layout defaults and word-role indices for the auto-load constant capture.
package al_const_pkg;
    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DONE, ERROR} state_e;
    localparam int AL_NWORDS = 34;
    localparam int AL_AW = 6;
    localparam logic [15:0] AL_MAGIC = 16'hDCFB;
    localparam int HDR_IDX = 0;
    localparam int CSUM_IDX = AL_NWORDS - 1;
endpackage

// File: rtl/al_const_capture_if.sv
// al_const_capture_if: sequencer/BPI-side capture handshake and active-bank read port of the constant capture block.
interface al_const_capture_if #(parameter int AW = 6);
    logic start_i;
    logic clr_al_done_i;
    logic capture_i;
    logic [AW-1:0] cnt_i;
    logic [15:0] data_in_i;
    logic [AW-1:0] rd_addr_i;
    logic [15:0] rd_data_o;
    logic al_done_o;
    logic const_valid_o;
    logic magic_err_o;
    logic seq_err_o;
    logic csum_err_o;
    logic tmo_err_o;
    logic [AW-1:0] word_cnt_o;
    modport master (
        output start_i, clr_al_done_i, capture_i, cnt_i, data_in_i, rd_addr_i,
        input rd_data_o, al_done_o, const_valid_o, magic_err_o, seq_err_o, csum_err_o, tmo_err_o, word_cnt_o
    );
    modport slave (
        input start_i, clr_al_done_i, capture_i, cnt_i, data_in_i, rd_addr_i,
        output rd_data_o, al_done_o, const_valid_o, magic_err_o, seq_err_o, csum_err_o, tmo_err_o, word_cnt_o
    );
endinterface

// File: rtl/al_const_capture_bank.sv
// al_const_bank: staging/active double bank; writes go to the inactive bank, commit toggles which one is read.
module al_const_bank
    import al_const_pkg::*;
#(
    parameter int NWORDS = AL_NWORDS,
    parameter int AW = AL_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic          commit_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);
    logic [15:0] bank_q [2][NWORDS];
    logic        act_q;
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) bank_q[~act_q][waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            act_q   <= act_q ^ commit_i;
            rdata_q <= ({1'b0, raddr_i} < (AW+1)'(NWORDS)) ? bank_q[act_q][raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/al_const_capture.sv
// al_const_capture: verifies an auto-load image (magic, order, checksum) and commits it atomically; watchdog via AL_TIMEOUT_EN.
module al_const_capture
    import al_const_pkg::*;
#(
    parameter int NWORDS = AL_NWORDS,
    parameter logic [15:0] MAGIC = AL_MAGIC,
`ifdef AL_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1024,
`endif
    parameter int AW = AL_AW
) (
    input logic clk,
    input logic rst,
    al_const_capture_if.slave bus
);
    localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]   sum_q, sum_d, csum_q, csum_d;
    logic          magic_err_q, magic_err_d;
    logic          seq_err_q, seq_err_d;
    logic          csum_err_q, csum_err_d;
    logic          al_done_q, al_done_d;
    logic          const_valid_q, const_valid_d;
    logic          take, accept, commit;

    assign take   = state_q == COLLECT && bus.capture_i && !bus.start_i;
    assign accept = take && bus.cnt_i == word_cnt_q && {1'b0, bus.cnt_i} < (AW+1)'(NWORDS);
    assign commit = state_q == DONE;

`ifdef AL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q, tmo_err_d;
    logic          tmo_hit;
    assign tmo_hit = state_q == COLLECT && tmo_q == TW'(TIMEOUT_CYC - 1);
    assign tmo_d   = (bus.start_i || accept || state_q != COLLECT) ? '0 : tmo_q + 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        sum_d         = sum_q;
        csum_d        = csum_q;
        magic_err_d   = magic_err_q;
        seq_err_d     = seq_err_q;
        csum_err_d    = csum_err_q;
        al_done_d     = bus.clr_al_done_i ? 1'b0 : al_done_q;
        const_valid_d = const_valid_q | commit;
`ifdef AL_TIMEOUT_EN
        tmo_err_d     = tmo_err_q;
`endif
        if (bus.start_i) begin
            state_d     = COLLECT;
            word_cnt_d  = '0;
            sum_d       = '0;
            magic_err_d = 1'b0;
            seq_err_d   = 1'b0;
            csum_err_d  = 1'b0;
            al_done_d   = 1'b0;
`ifdef AL_TIMEOUT_EN
            tmo_err_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        sum_d      = bus.cnt_i == LAST ? sum_q : sum_q + bus.data_in_i;
                        csum_d     = bus.cnt_i == LAST ? bus.data_in_i : csum_q;
                        state_d    = bus.cnt_i == LAST ? CHECK : COLLECT;
                        if (bus.cnt_i == AW'(HDR_IDX) && bus.data_in_i != MAGIC) begin
                            magic_err_d = 1'b1;
                            state_d     = ERROR;
                        end
                    end else if (take) begin
                        seq_err_d = 1'b1;
                        state_d   = ERROR;
                    end
`ifdef AL_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tmo_err_d = 1'b1;
                        state_d   = ERROR;
                    end
`endif
                end
                CHECK: begin
                    csum_err_d = sum_q != csum_q;
                    state_d    = sum_q == csum_q ? DONE : ERROR;
                end
                DONE, ERROR: begin
                    al_done_d = 1'b1;
                    state_d   = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            sum_q         <= '0;
            csum_q        <= '0;
            magic_err_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            csum_err_q    <= 1'b0;
            al_done_q     <= 1'b0;
            const_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            sum_q         <= sum_d;
            csum_q        <= csum_d;
            magic_err_q   <= magic_err_d;
            seq_err_q     <= seq_err_d;
            csum_err_q    <= csum_err_d;
            al_done_q     <= al_done_d;
            const_valid_q <= const_valid_d;
        end
    end

`ifdef AL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign bus.tmo_err_o = tmo_err_q;
`else
    assign bus.tmo_err_o = 1'b0;
`endif

    al_const_bank #(.NWORDS(NWORDS), .AW(AW)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we_i     (accept),
        .waddr_i  (bus.cnt_i),
        .wdata_i  (bus.data_in_i),
        .commit_i (commit),
        .raddr_i  (bus.rd_addr_i),
        .rdata_o  (bus.rd_data_o)
    );

    assign bus.al_done_o     = al_done_q;
    assign bus.const_valid_o = const_valid_q;
    assign bus.magic_err_o   = magic_err_q;
    assign bus.seq_err_o     = seq_err_q;
    assign bus.csum_err_o    = csum_err_q;
    assign bus.word_cnt_o    = word_cnt_q;
endmodule

// File: tb/tb_al_const_capture.sv
// tb_al_const_capture: directed vectors for good/bad images, ordering, restart, reset and read-port boundaries.
module tb_al_const_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    al_const_capture_if #(.AW(6)) bus();
    al_const_capture dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int i, input logic [15:0] d);
        bus.capture_i = 1'b1;
        bus.cnt_i = 6'(i);
        bus.data_in_i = d;
        tick();
        bus.capture_i = 1'b0;
    endtask

    task automatic pulse_start;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    function automatic logic [15:0] word(input int i, input logic [15:0] off, input logic [15:0] csum);
        return i == 0 ? 16'hDCFB : i == 33 ? csum : 16'(i) + off;
    endfunction

    task automatic words(input int from, input int to, input logic [15:0] off, input logic [15:0] csum);
        for (int i = from; i <= to; i++) cap(i, word(i, off, csum));
    endtask

    task automatic rd(input int a, input logic [15:0] exp, input string tag);
        bus.rd_addr_i = 6'(a);
        tick();
        check(tag, 32'(bus.rd_data_o), 32'(exp));
    endtask

    function automatic logic [3:0] flags;
        return {bus.magic_err_o, bus.seq_err_o, bus.csum_err_o, bus.tmo_err_o};
    endfunction

    initial begin
        bus.start_i = 1'b0;
        bus.clr_al_done_i = 1'b0;
        bus.capture_i = 1'b0;
        bus.cnt_i = '0;
        bus.data_in_i = '0;
        bus.rd_addr_i = '0;
        repeat (3) tick();
        check("rst_done", 32'(bus.al_done_o), 0);
        check("rst_valid", 32'(bus.const_valid_o), 0);
        check("rst_flags", 32'(flags()), 0);
        check("rst_wcnt", 32'(bus.word_cnt_o), 0);
        check("rst_rdata", 32'(bus.rd_data_o), 0);
        rst = 1'b0;
        tick();
        // good image: 0xDCFB + sum(1..32) = 0xDF0B
        pulse_start();
        words(0, 33, 16'h0000, 16'hDF0B);
        tick();
        check("good_done_k1", 32'(bus.al_done_o), 0);
        tick();
        check("good_done_k2", 32'(bus.al_done_o), 1);
        check("good_valid", 32'(bus.const_valid_o), 1);
        check("good_flags", 32'(flags()), 0);
        check("good_wcnt", 32'(bus.word_cnt_o), 34);
        rd(5, 16'h0005, "good_rd5");
        bus.clr_al_done_i = 1'b1;
        tick();
        bus.clr_al_done_i = 1'b0;
        check("clr_done", 32'(bus.al_done_o), 0);
        pulse_start();
        cap(0, 16'h1234);
        check("magic_err", 32'(bus.magic_err_o), 1);
        check("magic_done_k0", 32'(bus.al_done_o), 0);
        tick();
        check("magic_done_k1", 32'(bus.al_done_o), 1);
        check("magic_valid", 32'(bus.const_valid_o), 1);
        rd(5, 16'h0005, "magic_rd5");
        // second good image, constants offset by 0x100: checksum 0xDF0B + 0x2000
        pulse_start();
        check("start_clr_done", 32'(bus.al_done_o), 0);
        check("start_clr_flags", 32'(flags()), 0);
        words(0, 33, 16'h0100, 16'hFF0B);
        tick();
        tick();
        check("good2_done", 32'(bus.al_done_o), 1);
        check("good2_flags", 32'(flags()), 0);
        rd(5, 16'h0105, "good2_rd5");
        rd(40, 16'h0000, "rd_oob");
        rd(0, 16'hDCFB, "good2_rd0");
        rd(33, 16'hFF0B, "good2_rd33");
        pulse_start();
        words(0, 33, 16'h0200, 16'h1F0C);
        tick();
        check("csum_err", 32'(flags()), 32'h2);
        check("csum_done_k1", 32'(bus.al_done_o), 0);
        tick();
        check("csum_done_k2", 32'(bus.al_done_o), 1);
        check("csum_valid", 32'(bus.const_valid_o), 1);
        rd(5, 16'h0105, "csum_rd5");
        pulse_start();
        cap(0, 16'hDCFB);
        cap(1, 16'h0001);
        cap(3, 16'h0003);
        check("seq_err", 32'(flags()), 32'h4);
        check("seq_wcnt", 32'(bus.word_cnt_o), 2);
        tick();
        check("seq_done", 32'(bus.al_done_o), 1);
        rd(5, 16'h0105, "seq_rd5");
        pulse_start();
        words(0, 9, 16'h0300, 16'h0000);
        check("pre_restart_wcnt", 32'(bus.word_cnt_o), 10);
        bus.start_i = 1'b1;
        cap(10, 16'h030A);
        bus.start_i = 1'b0;
        check("restart_wcnt", 32'(bus.word_cnt_o), 0);
        check("restart_done", 32'(bus.al_done_o), 0);
        check("restart_flags", 32'(flags()), 0);
        words(0, 33, 16'h0300, 16'h3F0B);
        tick();
        tick();
        check("restart_good_done", 32'(bus.al_done_o), 1);
        check("restart_good_flags", 32'(flags()), 0);
        rd(5, 16'h0305, "restart_rd5");
        pulse_start();
        words(0, 3, 16'h0000, 16'h0000);
        repeat (40) tick();
        check("notmo_flag", 32'(bus.tmo_err_o), 0);
        check("notmo_done", 32'(bus.al_done_o), 0);
        cap(4, 16'h0004);
        check("notmo_wcnt", 32'(bus.word_cnt_o), 5);
        check("notmo_flags", 32'(flags()), 0);
        rst = 1'b1;
        tick();
        check("midrst_done", 32'(bus.al_done_o), 0);
        check("midrst_valid", 32'(bus.const_valid_o), 0);
        check("midrst_wcnt", 32'(bus.word_cnt_o), 0);
        check("midrst_rdata", 32'(bus.rd_data_o), 0);
        check("midrst_flags", 32'(flags()), 0);
        rst = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
